// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the hazard/NPC sequencing blocks.
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_WAIT    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         BUB_W              = 3;
    localparam int         LOAD_BUBBLES_DEF   = 1;
    localparam int         BRANCH_BUBBLES_DEF = 1;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources of the ID instruction.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    output logic       o_haz
);
    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
    // $zero never carries a real dependency, so a load to it cannot stall.
    assign o_haz = i_ex_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);
endmodule

// File: rtl/pc_hazard_ctrl.sv
// Drives the next-PC selector controls, IF/ID flush and ID/EX bubble from load-use,
// jump and branch events, and counts fetch-hold cycles.
module pc_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES   = LOAD_BUBBLES_DEF,
    parameter int BRANCH_BUBBLES = BRANCH_BUBBLES_DEF,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_beq,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_beq_taken,
    output logic             pc_sub_4_data,
    output logic             pc_sub_4_ctrl,
    output logic             beq_redirect,
    output logic             jump_redirect,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);
    if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 7) begin : g_bad_load_bubbles
        $error("pc_hazard_ctrl: LOAD_BUBBLES must be within 1..7");
    end
    if (BRANCH_BUBBLES < 1 || BRANCH_BUBBLES > 7) begin : g_bad_branch_bubbles
        $error("pc_hazard_ctrl: BRANCH_BUBBLES must be within 1..7");
    end

    localparam logic [BUB_W-1:0] LOAD_RELOAD = BUB_W'(LOAD_BUBBLES - 1);
    localparam logic [BUB_W-1:0] BR_RELOAD   = BUB_W'(BRANCH_BUBBLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [BUB_W-1:0] r_bub_cnt;
    logic [BUB_W-1:0] w_next_bub;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_haz;

    load_use_detect u_load_use_detect (
        .i_ex_mem_read (ex_mem_read),
        .i_ex_rt       (ex_rt),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_uses_rt  (id_uses_rt),
        .o_haz         (w_haz)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_bub    = r_bub_cnt;
        pc_sub_4_data = 1'b0;
        pc_sub_4_ctrl = 1'b0;
        beq_redirect  = 1'b0;
        jump_redirect = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            busy = (r_state != RUN);
            case (r_state)
                RUN: begin
                    if (w_haz) begin
                        pc_sub_4_data = 1'b1;
                        id_ex_bubble  = 1'b1;
                        // Single-bubble loads stay in RUN and re-check the same ID instruction.
                        if (LOAD_BUBBLES > 1) begin
                            w_next_state = LOAD_STALL;
                            w_next_bub   = LOAD_RELOAD;
                        end
                    end else if (id_jump) begin
                        jump_redirect = 1'b1;
                        if_id_flush   = 1'b1;
                    end else if (id_is_beq) begin
                        pc_sub_4_ctrl = 1'b1;
                        w_next_state  = BR_WAIT;
                        w_next_bub    = BR_RELOAD;
                    end
                end
                LOAD_STALL: begin
                    pc_sub_4_data = 1'b1;
                    id_ex_bubble  = 1'b1;
                    w_next_bub    = r_bub_cnt - 1'b1;
                    if (r_bub_cnt == BUB_W'(1)) w_next_state = RUN;
                end
                BR_WAIT: begin
                    if (r_bub_cnt != '0) begin
                        pc_sub_4_ctrl = 1'b1;
                        w_next_bub    = r_bub_cnt - 1'b1;
                    end else begin
                        beq_redirect = ex_beq_taken;
                        if_id_flush  = ex_beq_taken;
                        w_next_state = RUN;
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_bub_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_bub_cnt <= w_next_bub;
            if ((pc_sub_4_data || pc_sub_4_ctrl) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = rst ? '0 : r_stall_cnt;
endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Randomized and directed bench for pc_hazard_ctrl; two instances with different bubble counts share stimulus.
module tb_pc_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 0, id_is_beq = 0, id_jump = 0, ex_mem_read = 0, ex_beq_taken = 0;

    logic        d_data[2], d_ctrl[2], d_br[2], d_jr[2], d_fl[2], d_bub[2], d_busy[2];
    logic [15:0] cnt_o[2];
    logic [6:0]  obs[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_hazard_ctrl #(.LOAD_BUBBLES(1), .BRANCH_BUBBLES(2), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_beq(id_is_beq), .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_beq_taken(ex_beq_taken), .pc_sub_4_data(d_data[0]), .pc_sub_4_ctrl(d_ctrl[0]),
        .beq_redirect(d_br[0]), .jump_redirect(d_jr[0]), .if_id_flush(d_fl[0]),
        .id_ex_bubble(d_bub[0]), .busy(d_busy[0]), .stall_cnt(cnt_o[0]));

    pc_hazard_ctrl #(.LOAD_BUBBLES(3), .BRANCH_BUBBLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_beq(id_is_beq), .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_beq_taken(ex_beq_taken), .pc_sub_4_data(d_data[1]), .pc_sub_4_ctrl(d_ctrl[1]),
        .beq_redirect(d_br[1]), .jump_redirect(d_jr[1]), .if_id_flush(d_fl[1]),
        .id_ex_bubble(d_bub[1]), .busy(d_busy[1]), .stall_cnt(cnt_o[1]));

    assign obs[0] = {d_data[0], d_ctrl[0], d_br[0], d_jr[0], d_fl[0], d_bub[0], d_busy[0]};
    assign obs[1] = {d_data[1], d_ctrl[1], d_br[1], d_jr[1], d_fl[1], d_bub[1], d_busy[1]};

    // Reference: each instance is idle, holding a load for N more cycles, or waiting N cycles on a branch.
    int          lb[2] = '{1, 3};
    int          bb[2] = '{2, 1};
    int          m_mode[2], m_left[2], n_mode[2], n_left[2];
    int          m_cnt[2], n_cnt[2];
    logic [6:0]  exp_o[2];
    logic [15:0] exp_cnt[2];

    task automatic model_eval();
        for (int k = 0; k < 2; k++) begin
            bit haz, dat, ctl, br, jr, fl, bub;
            haz = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
            {dat, ctl, br, jr, fl, bub} = '0;
            n_mode[k] = m_mode[k];
            n_left[k] = m_left[k];
            if (rst) begin
                n_mode[k] = 0; n_left[k] = 0; n_cnt[k] = 0;
                exp_o[k] = '0; exp_cnt[k] = '0;
            end else begin
                if (m_mode[k] == 0) begin
                    if (haz) begin
                        dat = 1; bub = 1;
                        if (lb[k] > 1) begin n_mode[k] = 1; n_left[k] = lb[k] - 1; end
                    end else if (id_jump) begin
                        jr = 1; fl = 1;
                    end else if (id_is_beq) begin
                        ctl = 1; n_mode[k] = 2; n_left[k] = bb[k] - 1;
                    end
                end else if (m_mode[k] == 1) begin
                    dat = 1; bub = 1;
                    n_left[k] = m_left[k] - 1;
                    if (n_left[k] == 0) n_mode[k] = 0;
                end else begin
                    if (m_left[k] > 0) begin
                        ctl = 1; n_left[k] = m_left[k] - 1;
                    end else begin
                        br = ex_beq_taken; fl = ex_beq_taken; n_mode[k] = 0;
                    end
                end
                exp_o[k]   = {dat, ctl, br, jr, fl, bub, (m_mode[k] != 0)};
                exp_cnt[k] = 16'(m_cnt[k]);
                n_cnt[k]   = (dat || ctl) ? ((m_cnt[k] < 65535) ? m_cnt[k] + 1 : 65535) : m_cnt[k];
            end
        end
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = n_mode[k]; m_left[k] = n_left[k]; m_cnt[k] = n_cnt[k];
        end
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic beq, input logic jmp, input logic mr,
                          input logic [4:0] ert, input logic tkn);
        id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_beq = beq; id_jump = jmp;
        ex_mem_read = mr; ex_rt = ert; ex_beq_taken = tkn;
    endtask

    task automatic test_reset();
        rst = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin settle(); clk_edge(); end
        settle();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (obs[k] !== 7'b0 || cnt_o[k] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b/%0d expected 0000000/0", k, obs[k], cnt_o[k]);
            end
        end
        clk_edge();
        rst = 0;
    endtask

    task automatic test_load_use();
        // lw $2 in EX, add reading rs=2 in ID for one cycle, then quiet.
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_in(2, 5, 1, 0, 0, 1, 2, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL load_use[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
            end
            clk_edge();
        end
        // rt-only dependency and a load to $zero.
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      set_in(1, 7, 1, 0, 0, 1, 7, 0);
            else if (c == 4) set_in(0, 0, 1, 0, 0, 1, 0, 0);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL load_rt_r0[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (obs[0] !== 7'b0) begin
                    n_fail++;
                    $display("FAIL r0_no_stall: got %b expected 0000000", obs[0]);
                end
            end
            clk_edge();
        end
    endtask

    task automatic test_jump();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) set_in(3, 4, 1, 0, 1, 0, 0, 0);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL jump[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
            end
            if (c == 0) begin
                n_tests++;
                if (obs[0] !== 7'b0001100) begin
                    n_fail++;
                    $display("FAIL jump_direct: got %b expected 0001100", obs[0]);
                end
            end
            clk_edge();
        end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 0) set_in(0, 0, 0, 1, 0, 0, 0, t == 0);
                else        set_in(0, 0, 0, 0, 0, 0, 0, t == 0);
                settle();
                for (int k = 0; k < 2; k++) begin
                    n_tests++;
                    if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                        n_fail++;
                        $display("FAIL branch[%0d] tk%0d c%0d: got %b/%0d expected %b/%0d", k, 1 - t, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                    end
                end
                if (c == 2) begin
                    n_tests++;
                    if (obs[0] !== ((t == 0) ? 7'b0010101 : 7'b0000001)) begin
                        n_fail++;
                        $display("FAIL branch_resolve tk%0d: got %b", 1 - t, obs[0]);
                    end
                end
                clk_edge();
            end
        end
    endtask

    task automatic test_haz_jump();
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      set_in(2, 0, 0, 0, 1, 1, 2, 0);
            else if (c == 1) set_in(2, 0, 0, 0, 1, 0, 0, 0);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL haz_jump[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (d_jr[0] !== 1'b1 || d_data[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL haz_then_jump: got jr=%b data=%b expected jr=1 data=0", d_jr[0], d_data[0]);
                end
            end
            clk_edge();
        end
    endtask

    task automatic test_back_to_back();
        // Load stall, immediate second hazard, then a branch straight after.
        for (int c = 0; c < 12; c++) begin
            if (c < 5)       set_in(4, 0, 0, 0, 0, 1, 4, 1);
            else if (c == 5) set_in(0, 0, 0, 1, 0, 0, 0, 1);
            else             set_in(0, 0, 0, 0, 0, 0, 0, 1);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
            end
            clk_edge();
        end
    endtask

    task automatic test_reset_mid_branch();
        for (int c = 0; c < 4; c++) begin
            rst = (c == 1);
            if (c == 0) set_in(0, 0, 0, 1, 0, 0, 0, 1);
            else        set_in(0, 0, 0, 0, 0, 0, 0, 1);
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL rst_branch[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
                if (c == 2) begin
                    n_tests++;
                    if (obs[k] !== 7'b0 || cnt_o[k] !== 16'd0) begin
                        n_fail++;
                        $display("FAIL rst_abandon[%0d]: got %b/%0d expected 0000000/0", k, obs[k], cnt_o[k]);
                    end
                end
            end
            clk_edge();
        end
        rst = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 1'($urandom));
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (obs[k] !== exp_o[k] || cnt_o[k] !== exp_cnt[k]) begin
                    n_fail++;
                    $display("FAIL random[%0d] c%0d: got %b/%0d expected %b/%0d", k, c, obs[k], cnt_o[k], exp_o[k], exp_cnt[k]);
                end
            end
            clk_edge();
        end
        rst = 0;
    endtask

    task automatic test_saturate();
        set_in(6, 0, 0, 0, 0, 1, 6, 0);
        for (int c = 0; c < 65540; c++) begin settle(); clk_edge(); end
        for (int c = 0; c < 3; c++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (cnt_o[k] !== 16'hFFFF || obs[k] !== exp_o[k]) begin
                    n_fail++;
                    $display("FAIL saturate[%0d] c%0d: got %b/%h expected %b/ffff", k, c, obs[k], cnt_o[k], exp_o[k]);
                end
            end
            clk_edge();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_mode[k] = 0; m_left[k] = 0; m_cnt[k] = 0; end
        test_reset();
        test_load_use();
        test_jump();
        test_branch();
        test_haz_jump();
        test_back_to_back();
        test_reset_mid_branch();
        test_random();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
